// File: rtl/biu_fetch_resp.sv
// Fetch-line responder: takes an IFU line request, reads the line from memory as
// 64-bit beats and streams them back as response packets, then briefly masks new requests.
`ifndef PA_SIZE
`define PA_SIZE 32
`endif
`ifndef PKT_BITS
`define PKT_BITS 103
`endif
`ifndef PKT_VLD
`define PKT_VLD 102
`endif
`ifndef PKT_SIZE
`define PKT_SIZE 101:100
`endif
`ifndef PKT_LAST
`define PKT_LAST 99
`endif
`ifndef PKT_TYPE
`define PKT_TYPE 98:96
`endif
`ifndef PKT_ADDR
`define PKT_ADDR 95:64
`endif
`ifndef PKT_DATA
`define PKT_DATA 63:0
`endif
`ifndef PKT_TYPE_FETCH
`define PKT_TYPE_FETCH 3'd1
`endif
`ifndef REQ_SZ_LINE
`define REQ_SZ_LINE 2'd3
`endif

module biu_fetch_resp #(
    parameter int LINE_BEATS = 2,
    parameter int HOLDOFF    = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [`PKT_BITS-1:0] ifu_req_pkt_xx,
    output logic [`PKT_BITS-1:0] biu_resp_pkt_xx,
    output logic                 mem_req_vld,
    input  logic                 mem_req_rdy,
    output logic [`PA_SIZE-1:0]  mem_req_addr,
    input  logic                 mem_rsp_vld,
    input  logic [63:0]          mem_rsp_data,
    output logic                 busy
);

    localparam int CW    = $clog2(LINE_BEATS) + 1;
    localparam int OFF_W = $clog2(LINE_BEATS) + 3;
    localparam int HW    = $clog2(HOLDOFF + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] FILL = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [`PA_SIZE-1:0]  line_q, line_d;
    logic [CW-1:0]        req_cnt_q, req_cnt_d;
    logic [CW-1:0]        rsp_cnt_q, rsp_cnt_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [CW-1:0]        gate_q, gate_d;
    logic [`PKT_BITS-1:0] resp_q, resp_d;

    logic req_take;
    logic rsp_take;
    logic last_sent;
    logic rsp_err;
    logic unused_req_bits;

    assign unused_req_bits = ^{ifu_req_pkt_xx[`PKT_LAST], ifu_req_pkt_xx[`PKT_DATA],
                               ifu_req_pkt_xx[OFF_W+63:64]};

    always_comb begin
        req_take = (state_q == IDLE) && ifu_req_pkt_xx[`PKT_VLD]
                   && (ifu_req_pkt_xx[`PKT_TYPE] == `PKT_TYPE_FETCH)
                   && (ifu_req_pkt_xx[`PKT_SIZE] == `REQ_SZ_LINE);
        rsp_take = (state_q == FILL) && mem_rsp_vld && (rsp_cnt_q < CW'(LINE_BEATS));
        // The LAST packet is on the bus for one cycle before FILL hands over to HOLD
        last_sent = resp_q[`PKT_VLD] && resp_q[`PKT_LAST];
        rsp_err = mem_rsp_vld && !rsp_take && (gate_q == '0);
        mem_req_vld  = (state_q == FILL) && (req_cnt_q < CW'(LINE_BEATS));
        mem_req_addr = line_q + (`PA_SIZE'(req_cnt_q) << 3);
        busy = (state_q != IDLE);
    end

    always_comb begin
        state_d    = state_q;
        line_d     = line_q;
        req_cnt_d  = req_cnt_q;
        rsp_cnt_d  = rsp_cnt_q;
        hold_cnt_d = hold_cnt_q;
        gate_d     = (gate_q != '0) ? gate_q - 1'b1 : gate_q;
        resp_d     = '0;

        case (state_q)
            IDLE: begin
                if (req_take) begin
                    state_d   = FILL;
                    line_d    = {ifu_req_pkt_xx[`PA_SIZE+63:OFF_W+64], OFF_W'(0)};
                    req_cnt_d = '0;
                    rsp_cnt_d = '0;
                end
            end
            FILL: begin
                if (mem_req_vld && mem_req_rdy)
                    req_cnt_d = req_cnt_q + 1'b1;
                if (rsp_take)
                    rsp_cnt_d = rsp_cnt_q + 1'b1;
                if (last_sent) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                hold_cnt_d = hold_cnt_q + 1'b1;
                if (hold_cnt_q == HW'(HOLDOFF - 1))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (rsp_take) begin
            resp_d[`PKT_VLD]  = 1'b1;
            resp_d[`PKT_TYPE] = `PKT_TYPE_FETCH;
            resp_d[`PKT_SIZE] = `REQ_SZ_LINE;
            resp_d[`PKT_ADDR] = line_q + (`PA_SIZE'(rsp_cnt_q) << 3);
            resp_d[`PKT_DATA] = mem_rsp_data;
            resp_d[`PKT_LAST] = (rsp_cnt_q == CW'(LINE_BEATS - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            line_q     <= '0;
            req_cnt_q  <= '0;
            rsp_cnt_q  <= '0;
            hold_cnt_q <= '0;
            gate_q     <= CW'(LINE_BEATS);
            resp_q     <= '0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            req_cnt_q  <= req_cnt_d;
            rsp_cnt_q  <= rsp_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            gate_q     <= gate_d;
            resp_q     <= resp_d;
        end
    end

    assign biu_resp_pkt_xx = resp_q;

    // Stray read data is dropped; responses still in flight across a reset are expected
    assert property (@(posedge clk) disable iff (reset) !rsp_err)
        else $error("biu_fetch_resp: unexpected mem_rsp_vld dropped");

endmodule
